// File: rtl/proc_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : proc_ctrl_pkg                                              |
// | Description : Shared definitions for the soft-processor run controller: |
// |               FSM state encoding, default widths and a small helper.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package proc_ctrl_pkg;

  // Default width of the prescaler and of the issued-tick counter.
  localparam int c_default_cnt_w   = 32;
  // Default width of the speed switch field (period exponent).
  localparam int c_default_speed_w = 5;

  // Controller states. The encoding is visible on the 'state' port and is
  // shown on the front panel, so the values are fixed.
  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } run_state_t;

  // Rising-edge detect for a level that has already been debounced.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tick_prescaler                                             |
// | Description : Free-running period counter for the processor tick.       |
// |               Period is 2^i_speed clock cycles; o_terminal is high in   |
// |               the last cycle of each period.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   system clock                                           |
// |   rst        in   synchronous active-high reset (counter -> 0)          |
// |   i_clear    in   synchronous restart of the period (counter -> 0)      |
// |   i_speed    in   period exponent, P = 2^i_speed                         |
// |   o_terminal out  counter has reached P-1 (or beyond)                    |
// +--------------------------------------------------------------------------+
module tick_prescaler
  import proc_ctrl_pkg::*;
#(
  parameter int CNT_W   = c_default_cnt_w,
  parameter int SPEED_W = c_default_speed_w
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic [SPEED_W-1:0] i_speed,
  output logic               o_terminal
);

  localparam logic [CNT_W-1:0] c_ones = '1;
  localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;

  // P-1 as a low-order mask. Exponents at or beyond CNT_W shift every bit
  // out, so the limit saturates at all-ones rather than wrapping.
  assign w_limit = ~(c_ones << i_speed);

  // Greater-or-equal so that lowering the speed while the counter is already
  // past the new limit ends the period at once instead of waiting for a wrap.
  assign o_terminal = (r_cnt >= w_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_terminal) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/proc_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : proc_run_controller                                        |
// | Description : Sequencing controller for the soft processor. Produces a  |
// |               one-cycle clock enable (proc_ce) on clk at a rate set by  |
// |               the speed switches, with free-run, single-step and        |
// |               halt-stop modes, and counts the ticks issued.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk         in   system clock, single domain                           |
// |   rst         in   synchronous active-high reset                         |
// |   speed       in   tick period exponent, P = 2^speed clk cycles          |
// |   run         in   debounced level, 1 requests free-run                  |
// |   step        in   debounced level, each rising edge requests one tick   |
// |   halt        in   processor halt status (level)                         |
// |   proc_ce     out  registered one-cycle processor clock enable           |
// |   state       out  current controller state (package encoding)          |
// |   tick_count  out  number of proc_ce pulses issued, saturating          |
// +--------------------------------------------------------------------------+
module proc_run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int CNT_W   = c_default_cnt_w,
  parameter int SPEED_W = c_default_speed_w
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  input  logic               run,
  input  logic               step,
  input  logic               halt,
  output logic               proc_ce,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   tick_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  run_state_t       r_state;
  run_state_t       w_state_nxt;
  logic             r_step_d;
  logic             r_proc_ce;
  logic [CNT_W-1:0] r_tick_count;

  logic             w_terminal;
  logic             w_clear;
  logic             w_step_edge;
  logic             w_tick;

  // ---------------------------------------------------------------------------
  // Period counter. It restarts on every state change so that a RUN session
  // or the post-reset HOLD wait always begins with a full period.
  // ---------------------------------------------------------------------------
  tick_prescaler #(
    .CNT_W   (CNT_W),
    .SPEED_W (SPEED_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_speed    (speed),
    .o_terminal (w_terminal)
  );

  assign w_clear = (w_state_nxt != r_state);

  // r_step_d resets to 1 so a button held through reset is not seen as a
  // fresh press when reset releases.
  assign w_step_edge = rise_edge(step, r_step_d);

  // ---------------------------------------------------------------------------
  // Next-state and tick decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    case (r_state)
      ST_HOLD: begin
        // One full period of quiet after reset before accepting commands.
        if (w_terminal) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (halt)             w_state_nxt = ST_HALTED;
        else if (run)         w_state_nxt = ST_RUN;
        else if (w_step_edge) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        // Halt and run-drop both take precedence over a tick that falls in
        // the same cycle, so no enable escapes after either request.
        if (halt)            w_state_nxt = ST_HALTED;
        else if (!run)       w_state_nxt = ST_PAUSE;
        else if (w_terminal) w_tick      = 1'b1;
      end
      ST_STEP: begin
        w_state_nxt = ST_PAUSE;
      end
      ST_HALTED: begin
        // Leaving HALTED needs run low as well, so the operator has to
        // acknowledge the halt before the processor can be restarted.
        if (!halt && !run) w_state_nxt = ST_PAUSE;
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HOLD;
      r_step_d     <= 1'b1;
      r_proc_ce    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_step_d <= step;
      // The enable is high during the whole STEP cycle, and for one cycle
      // after each terminal count seen while running.
      r_proc_ce <= w_tick | (w_state_nxt == ST_STEP);
      if (r_proc_ce && (r_tick_count != c_cnt_max)) begin
        r_tick_count <= r_tick_count + c_cnt_one;
      end
    end
  end

  assign proc_ce    = r_proc_ce;
  assign state      = r_state;
  assign tick_count = r_tick_count;

endmodule
`default_nettype wire

// File: doc/proc_run_controller.md
# proc_run_controller

Sequencing controller for the soft processor's execution clock. It replaces free-running clock division with a single-clock-domain enable pulse, `proc_ce`, so the processor and its display logic stay on `clk`. The rate of `proc_ce` is set by the `speed` switches. The block supports free-run, single-step and halt-stop modes, and counts issued ticks for display on the seven-segment output. It sits between the debounced switch/button inputs and the processor core.

## Interface
Parameters:
- `CNT_W`, 32: width of the prescaler and of `tick_count`.
- `SPEED_W`, 5: width of the `speed` input. Period exponent range is 0..2^SPEED_W-1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `speed`  in  SPEED_W  tick period is P = 2^speed clk cycles.
- `run`  in  1  debounced level; 1 = free-run requested.
- `step`  in  1  debounced level; each rising edge requests one tick.
- `halt`  in  1  processor halt status (level).
- `proc_ce`  out  1  registered, one-cycle-wide processor clock enable.
- `state`  out  3  current FSM state (package encoding).
- `tick_count`  out  CNT_W  number of `proc_ce` pulses issued; saturating.

## Operation
- Reset values:
  - `state` = HOLD
  - `proc_ce` = 0
  - `tick_count` = 0
  - prescaler = 0
  - step edge register = 1, which suppresses a spurious edge if `step` is held through reset.
- Prescaler:
  - Increments every cycle.
  - Terminal condition: cnt >= ~({CNT_W{1}} << speed), i.e. cnt >= P-1. The compare is `>=`, so lowering `speed` mid-count terminates immediately.
  - On terminal, the prescaler reloads 0.
  - It is also cleared on every state transition.
- Step edge: `step & ~step_d`. Edges are honoured only in PAUSE. Edges arriving in any other state are dropped, not queued.
- FSM:
  - HOLD: no `proc_ce`. Waits one full prescaler period after reset, then goes to PAUSE.
  - PAUSE: priority order is
    - `halt`=1 → HALTED
    - else `run`=1 → RUN
    - else step edge → STEP
  - RUN: priority order is
    - `halt`=1 → HALTED, no tick
    - else `run`=0 → PAUSE, no tick even if terminal
    - else on terminal, issue a tick
  - STEP: `proc_ce`=1 for exactly this cycle, then → PAUSE unconditionally.
  - HALTED: no ticks. Goes to PAUSE only when `halt`=0 AND `run`=0, so the operator must drop `run` to acknowledge a halt.
- `tick_count` increments in the cycle after `proc_ce`=1 and saturates at all-ones (no wrap).
- `rst` mid-operation: all state returns to reset values at the next edge. `proc_ce` is 0 in the first cycle after `rst` is sampled high.

## Timing
- PAUSE→RUN:
  - `run` sampled at edge ending cycle N; state=RUN and cnt=0 in cycle N+1.
  - First `proc_ce` in cycle N+1+P, then every P cycles.
- speed=0 (P=1): `proc_ce` is high every cycle from N+2 while RUN holds.
- Step:
  - Edge observed in cycle N (PAUSE).
  - state=STEP and `proc_ce`=1 in cycle N+1.
  - state=PAUSE in N+2.
- `halt` asserted in RUN cycle N: state=HALTED in N+1, and no `proc_ce` in N+1 even if cycle N was terminal.
- HOLD: after `rst` deasserts, state=PAUSE after P cycles. The P used is the `speed` value during the count.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `proc_ctrl_pkg`:
  - state encoding HOLD=0, PAUSE=1, RUN=2, STEP=3, HALTED=4
  - `CNT_W` and `SPEED_W` defaults
- Sub-module `tick_prescaler`: counter, `speed`-based terminal compare, and synchronous clear input; outputs a `terminal` flag.
- Top level holds the FSM, the step edge detector, `proc_ce` and `tick_count` registers.

## Test plan
- Reset, speed=2, run=0 → PAUSE reached 4 cycles after reset release; `proc_ce` stays 0; `tick_count`=0.
- From PAUSE, speed=3, run=1 for 40 cycles → first `proc_ce` at cycle N+9, then every 8 cycles; `tick_count`=4 after N+33.
- Three step edges spaced 10 cycles apart in PAUSE, plus one extra edge while in STEP → exactly three one-cycle `proc_ce` pulses, each 1 cycle after its edge; `tick_count`=3.
- RUN at speed=0; assert `halt` in cycle M → last `proc_ce` in cycle M; state=HALTED in M+1. Deassert `halt` with run=1 → stays HALTED. Set run=0 → PAUSE.
- RUN at speed=10; lower speed to 1 when cnt=500 → terminal fires next cycle; `proc_ce` follows; thereafter every 2 cycles.
- Preload `tick_count` near max (force or CNT_W=4 build) and run → saturates at all-ones. Assert `rst` mid-RUN → `proc_ce`=0 next cycle; state=HOLD; `tick_count`=0.
